// File: rtl/ravenoc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ravenoc_pkg
// Description : Shared NoC types: flit layout, link request/response
//               structs, router port directions and the XY route helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ravenoc_pkg;

  localparam int NumVirtChn    = 2;
  localparam int VcWidth       = $clog2(NumVirtChn);
  localparam int FlitWidth     = 34;
  localparam int XWidth        = 2;
  localparam int YWidth        = 2;
  localparam int PktWidth      = 8;
  localparam int FlitDataWidth = FlitWidth - 2 - XWidth - YWidth - PktWidth;
  localparam int BufDepthDef   = 4;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } s_flit_type_t;

  typedef enum logic {
    ZeroHighPrior = 1'b0,
    ZeroLowPrior  = 1'b1
  } s_prior_t;

  localparam s_prior_t HighPriority = ZeroLowPrior;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    WEST  = 3'd2,
    EAST  = 3'd3,
    LOCAL = 3'd4
  } s_router_ports_t;

  typedef struct packed {
    s_flit_type_t               type_f;
    logic [XWidth-1:0]          x_dest;
    logic [YWidth-1:0]          y_dest;
    logic [PktWidth-1:0]        pkt_size;
    logic [FlitDataWidth-1:0]   data;
  } s_flit_head_data_t;

  typedef struct packed {
    logic                 valid;
    logic [VcWidth-1:0]   vc_id;
    logic [FlitWidth-1:0] fdata;
  } s_flit_req_t;

  typedef struct packed {
    logic ready;
  } s_flit_resp_t;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic s_router_ports_t xy_route(input logic [XWidth-1:0] x_dest,
                                               input logic [YWidth-1:0] y_dest,
                                               input logic [XWidth-1:0] x_cur,
                                               input logic [YWidth-1:0] y_cur);
    s_router_ports_t dir;
    if (x_dest > x_cur)      dir = EAST;
    else if (x_dest < x_cur) dir = WEST;
    else if (y_dest > y_cur) dir = SOUTH;
    else if (y_dest < y_cur) dir = NORTH;
    else                     dir = LOCAL;
    return dir;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vc_input_module_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vc_fifo
// Description : Single virtual-channel synchronous FIFO with full/empty.
//               Pointers carry an extra wrap bit; read data is the head
//               entry, available combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_fifo
  import ravenoc_pkg::*;
#(
  parameter int DEPTH = BufDepthDef,
  parameter int WIDTH = FlitWidth
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer advance; a simultaneous push and pop leaves occupancy unchanged.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (rd_en && !empty) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !full) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/vc_input_module.sv
`default_nettype none
// ============================================================================
// Module      : vc_input_module
// Description : Router input port. Buffers incoming flits per VC, computes
//               the XY route of head flits, locks the route per VC for the
//               packet duration and offers one flit per cycle to the output
//               module selected by the route.
// Options     : RAVENOC_IN_CHECK_EN - drop protocol-violating flits and
//               raise the sticky err_o flag.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_input_module
  import ravenoc_pkg::*;
#(
  parameter s_router_ports_t PORT_DIR  = NORTH,
  parameter int              BUF_DEPTH = BufDepthDef,
  parameter int              NUM_VC    = NumVirtChn
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [XWidth-1:0]       router_x_i,
  input  logic [YWidth-1:0]       router_y_i,
  input  s_flit_req_t             fin_req_i,
  output s_flit_resp_t            fin_resp_o,
  output s_flit_req_t  [4:0]      fout_req_o,
  input  s_flit_resp_t [4:0]      fout_resp_i,
  output logic                    err_o
);

  // Slots beyond NUM_VC are padded as permanently full and empty so that
  // any vc_id value indexes safely.
  localparam int c_vc_slots = 1 << VcWidth;

  logic [c_vc_slots-1:0] w_full;
  logic [c_vc_slots-1:0] w_empty;
  logic [c_vc_slots-1:0] w_wr_en;
  logic [c_vc_slots-1:0] w_rd_en;
  logic [FlitWidth-1:0]  w_rd_data [c_vc_slots];

  logic [c_vc_slots-1:0] lock_ff;
  s_router_ports_t       route_ff [c_vc_slots];
  logic [VcWidth-1:0]    sel_vc_ff;
  logic                  pend_ff;

  logic [VcWidth-1:0]    w_pick_vc;
  logic                  w_pick_found;
  logic [VcWidth-1:0]    w_cur_vc;
  logic                  w_cur_valid;
  s_flit_head_data_t     w_head;
  logic                  w_locked;
  logic                  w_is_head;
  logic                  w_is_tail;
  s_router_ports_t       w_route;
  logic                  w_drop;
  logic                  w_accept;
  logic                  w_deq;
  logic                  w_unused;

  assign fin_resp_o.ready = !arst && !w_full[fin_req_i.vc_id];

  for (genvar v = 0; v < c_vc_slots; v++) begin : g_vc
    if (v < NUM_VC) begin : g_fifo
      assign w_wr_en[v] = fin_req_i.valid && fin_resp_o.ready &&
                          (fin_req_i.vc_id == VcWidth'(v));
      vc_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (FlitWidth)
      ) u_fifo (
        .clk     (clk),
        .arst    (arst),
        .wr_en   (w_wr_en[v]),
        .wr_data (fin_req_i.fdata),
        .rd_en   (w_rd_en[v]),
        .rd_data (w_rd_data[v]),
        .full    (w_full[v]),
        .empty   (w_empty[v])
      );
    end else begin : g_pad
      assign w_wr_en[v]   = 1'b0;
      assign w_full[v]    = 1'b1;
      assign w_empty[v]   = 1'b1;
      assign w_rd_data[v] = '0;
    end
  end

  // Priority pick among nonempty VCs; the last match in scan order wins.
  always_comb begin
    w_pick_vc    = '0;
    w_pick_found = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!w_empty[(HighPriority == ZeroLowPrior) ? i : (NUM_VC - 1 - i)]) begin
        w_pick_vc    = VcWidth'((HighPriority == ZeroLowPrior) ? i : (NUM_VC - 1 - i));
        w_pick_found = 1'b1;
      end
    end
  end

  assign w_cur_vc    = pend_ff ? sel_vc_ff : w_pick_vc;
  assign w_cur_valid = pend_ff || w_pick_found;
  assign w_head      = s_flit_head_data_t'(w_rd_data[w_cur_vc]);
  assign w_locked    = lock_ff[w_cur_vc];
  assign w_is_head   = (w_head.type_f == HEAD_FLIT);
  assign w_is_tail   = (w_head.type_f == TAIL_FLIT);
  assign w_route     = w_locked ? route_ff[w_cur_vc]
                                : xy_route(w_head.x_dest, w_head.y_dest,
                                           router_x_i, router_y_i);

`ifdef RAVENOC_IN_CHECK_EN
  logic err_ff;

  assign w_drop = w_cur_valid &&
                  ((w_is_head && w_locked) ||
                   (!w_is_head && !w_locked) ||
                   (w_is_head && !w_locked && (w_route == PORT_DIR)));
  assign err_o  = err_ff;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge arst) begin
    if (arst)        err_ff <= 1'b0;
    else if (w_drop) err_ff <= 1'b1;
  end
`else
  assign w_drop = 1'b0;
  assign err_o  = 1'b0;
`endif

  // Payload bits are never inspected here; the U-turn compare is only
  // consumed by the checking build.
  assign w_unused = ^{w_head.data, (w_route == PORT_DIR)};

  // Egress: drive only the routed output; dropped flits are consumed silently.
  always_comb begin
    fout_req_o = '0;
    w_accept   = 1'b0;
    w_rd_en    = '0;
    if (w_cur_valid && !w_drop) begin
      fout_req_o[w_route].valid = 1'b1;
      fout_req_o[w_route].vc_id = w_cur_vc;
      fout_req_o[w_route].fdata = w_rd_data[w_cur_vc];
      w_accept                  = fout_resp_i[w_route].ready;
    end
    w_deq = w_accept || (w_cur_valid && w_drop);
    if (w_deq) w_rd_en[w_cur_vc] = 1'b1;
  end

  // Selection hold and per-VC route lock bookkeeping.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      lock_ff   <= '0;
      sel_vc_ff <= '0;
      pend_ff   <= 1'b0;
      for (int i = 0; i < c_vc_slots; i++) route_ff[i] <= NORTH;
    end else begin
      if (w_cur_valid) sel_vc_ff <= w_cur_vc;
      pend_ff <= w_cur_valid && !w_deq;
      if (w_accept) begin
        if (w_is_head && (w_head.pkt_size != '0)) begin
          lock_ff[w_cur_vc]  <= 1'b1;
          route_ff[w_cur_vc] <= w_route;
        end
        if (w_is_tail) lock_ff[w_cur_vc] <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
